// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver FSM states and the default frame width
// also used by parallel2serial.
package serial_pkg;

  localparam int SERIAL_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_t;

endpackage

// File: rtl/s2p_bit_counter.sv
// Bit-position counter for the deserializer: clear, load-to-1 on a frame start, increment per
// bit, and a terminal flag when the last bit position (WIDTH-1) is reached.
module s2p_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/serial2parallel.sv
// LSB-first deserializer framed by serial_start/serial_end; presents each word on q with a
// one-cycle parallel_valid strobe. Define S2P_FRAME_CHECK_EN to build the framing checks.
module serial2parallel
  import serial_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             serial_start,
  input  logic             serial_end,
  output logic [WIDTH-1:0] q,
  output logic             parallel_valid,
  output logic             busy,
  output logic             frame_error
);

  localparam int CW = $clog2(WIDTH);

  s2p_state_t       state, next_state;
  logic [WIDTH-1:0] sr, next_sr, word;
  logic [CW-1:0]    count;
  logic             terminal;
  logic             cnt_load, cnt_inc, cnt_clr;
  logic             load_q, err;
  logic             end_in, restart_in;

`ifdef S2P_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
  assign end_in     = serial_end;
  assign restart_in = serial_start;
`else
  localparam bit CHECK_EN = 1'b0;
  assign end_in     = 1'b0;
  assign restart_in = 1'b0;
  logic unused_check;
  assign unused_check = &{1'b0, serial_end, err};
`endif

  s2p_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .count    (count),
    .terminal (terminal)
  );

  always_comb begin
    word        = sr;
    word[count] = d;
    next_state  = state;
    next_sr     = sr;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    load_q      = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        if (serial_start) begin
          if (end_in) begin
            err = 1'b1;
          end else begin
            next_state = SHIFT;
            next_sr    = {{(WIDTH-1){1'b0}}, d};
            cnt_load   = 1'b1;
          end
        end
      end
      SHIFT: begin
        // A start inside a frame abandons the partial word and restarts at bit 0.
        if (restart_in) begin
          err = 1'b1;
          if (end_in) begin
            next_state = IDLE;
            next_sr    = '0;
            cnt_clr    = 1'b1;
          end else begin
            next_sr  = {{(WIDTH-1){1'b0}}, d};
            cnt_load = 1'b1;
          end
        end else if (terminal) begin
          next_state = IDLE;
          next_sr    = '0;
          cnt_clr    = 1'b1;
          if (end_in || !CHECK_EN) load_q = 1'b1;
          else                     err    = 1'b1;
        end else if (end_in) begin
          err        = 1'b1;
          next_state = IDLE;
          next_sr    = '0;
          cnt_clr    = 1'b1;
        end else begin
          next_sr = word;
          cnt_inc = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      sr             <= '0;
      q              <= '0;
      parallel_valid <= 1'b0;
    end else begin
      state          <= next_state;
      sr             <= next_sr;
      parallel_valid <= load_q;
      if (load_q) q <= word;
    end
  end

`ifdef S2P_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) frame_error <= 1'b0;
    else       frame_error <= err;
  end
`else
  assign frame_error = 1'b0;
`endif

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial2parallel.sv
// Randomised and directed bench for serial2parallel with a queue-based scoreboard checked
// against a bit-list reference model of the framing rules.
module tb_serial2parallel;

  localparam int W = 8;
`ifdef S2P_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         d = 1'b0;
  logic         serial_start = 1'b0;
  logic         serial_end = 1'b0;
  logic [W-1:0] q;
  logic         parallel_valid;
  logic         busy;
  logic         frame_error;

  serial2parallel #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .d              (d),
    .serial_start   (serial_start),
    .serial_end     (serial_end),
    .q              (q),
    .parallel_valid (parallel_valid),
    .busy           (busy),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [W-1:0] word;
  } ev_t;

  ev_t          evq[$];
  bit           bits[$];
  logic [W-1:0] exp_q = '0;
  logic         exp_busy = 1'b0;
  int           total = 0;
  int           passed = 0;
  int           cyc = 0;
  int           busy_cycles = 0;
  int           pv_cycles[$];
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_ev(input bit is_err, input logic [W-1:0] w);
    ev_t e;
    e.is_err = is_err;
    e.word   = w;
    evq.push_back(e);
  endfunction

  // Reference: a frame is the list of bits collected so far; empty list means idle.
  function automatic void model(input logic rst, input logic dd, input logic ss, input logic ee);
    logic [W-1:0] w;
    if (rst) begin
      bits.delete();
      exp_q = '0;
    end else if (bits.size() == 0) begin
      if (ss) begin
        if (CHK && ee) push_ev(1'b1, '0);
        else bits.push_back(dd);
      end
    end else if (CHK && ss) begin
      push_ev(1'b1, '0);
      bits.delete();
      if (!ee) bits.push_back(dd);
    end else begin
      bits.push_back(dd);
      if (bits.size() == W) begin
        if (!CHK || ee) begin
          w = '0;
          foreach (bits[i]) w[i] = bits[i];
          exp_q = w;
          push_ev(1'b0, w);
        end else begin
          push_ev(1'b1, '0);
        end
        bits.delete();
      end else if (CHK && ee) begin
        push_ev(1'b1, '0);
        bits.delete();
      end
    end
    exp_busy = (bits.size() != 0);
  endfunction

  task automatic tick(input logic rst, input logic dd, input logic ss, input logic ee);
    reset = rst; d = dd; serial_start = ss; serial_end = ee;
    @(posedge clk);
    model(rst, dd, ss, ee);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input int nbits, input int end_at);
    for (int i = 0; i < nbits; i++) tick(1'b0, w[i], i == 0, i == end_at);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      cyc++;
      if (busy === 1'b1) busy_cycles++;
      check("busy", busy, exp_busy);
      check("q_hold", q, exp_q);
      if (parallel_valid === 1'b1 && frame_error === 1'b1) check("pv_fe_overlap", 1, 0);
      if (parallel_valid === 1'b1 || frame_error === 1'b1) begin
        if (parallel_valid === 1'b1) pv_cycles.push_back(cyc);
        if (evq.size() == 0) begin
          check("unexpected_pulse", {parallel_valid, frame_error}, 0);
        end else begin
          e = evq.pop_front();
          check("event_kind", frame_error, e.is_err);
          if (!e.is_err) check("word", q, e.word);
        end
      end else if (evq.size() != 0) begin
        e = evq.pop_front();
        check("missing_pulse", 0, e.is_err ? 2 : 1);
      end
    end
  end

  initial begin
    int n0, b0;
    logic [W-1:0] w;

    tick(1'b1, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    for (int i = 0; i < 11; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    check("rst_q", q, 0);
    check("rst_pv", parallel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fe", frame_error, 0);

    // reset mid-frame after three bits
    send(8'hFF, 3, -1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("midrst_busy", busy, 0);
    idle(3);

    b0 = busy_cycles;
    n0 = pv_cycles.size();
    send(8'hD3, W, W - 1);
    idle(3);
    check("d3_q", q, 8'hD3);
    check("d3_pulses", pv_cycles.size() - n0, 1);
    check("d3_busy_len", busy_cycles - b0, 7);

    n0 = pv_cycles.size();
    send(8'hD3, W, W - 1);
    send(8'h5A, W, W - 1);
    idle(2);
    check("b2b_pulses", pv_cycles.size() - n0, 2);
    if (pv_cycles.size() >= n0 + 2) check("b2b_gap", pv_cycles[n0 + 1] - pv_cycles[n0], 8);
    check("b2b_q", q, 8'h5A);

    send(8'hD3, W, W - 1);
    idle(1);
    send(8'h3C, 5, 4);
    idle(6);
`ifdef S2P_FRAME_CHECK_EN
    check("early_end_q", q, 8'hD3);
`endif

    send(8'h96, W, -1);
    idle(3);
`ifndef S2P_FRAME_CHECK_EN
    check("no_end_q", q, 8'h96);
`endif

    send(8'h07, 3, -1);
    send(8'hA5, W, W - 1);
    idle(3);
`ifdef S2P_FRAME_CHECK_EN
    check("restart_q", q, 8'hA5);
`endif

    for (int f = 0; f < 30; f++) begin
      w = W'($urandom);
      send(w, W, W - 1);
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);

    idle(W + 2);
    check("queue_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
